// File: rtl/rv_cpu_single_cycle.sv
`default_nettype none
// ============================================================================
//  Module      : rv_cpu_single_cycle
//  Description : Single-cycle RV32I-subset core. Fetch, decode, execute,
//                memory access and writeback complete in one clock. The
//                instruction and data memories are internal arrays
//                (u_imem.imem, u_mem.mem); the register file is
//                u_regfile.regs. Optional macro RV_EXT_BRANCH_EN adds
//                bne/blt/bge/bltu/bgeu next to beq.
//  Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// Instruction memory: combinational read, word index wraps at DEPTH.
// ----------------------------------------------------------------------------
module rv_cpu_imem #(
    parameter int DEPTH = 256
) (
    input  logic [29:0] i_word_addr,
    output logic [31:0] o_instr
);
    localparam int c_ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0]         imem [0:DEPTH-1];
    logic [c_ADDR_W-1:0] w_index;

    assign w_index = c_ADDR_W'(i_word_addr % 30'(DEPTH));
    assign o_instr = imem[w_index];
endmodule

// ----------------------------------------------------------------------------
// Register file: two combinational read ports, one write port. x0 reads 0.
// ----------------------------------------------------------------------------
module rv_cpu_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  i_rs1_addr,
    input  logic [4:0]  i_rs2_addr,
    output logic [31:0] o_rs1_data,
    output logic [31:0] o_rs2_data,
    input  logic        i_we,
    input  logic [4:0]  i_rd_addr,
    input  logic [31:0] i_rd_data
);
    logic [31:0] regs [0:31];

    // Clear all registers on reset, otherwise commit one write; x0 is never written
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (i_we && (i_rd_addr != 5'd0)) begin
            regs[i_rd_addr] <= i_rd_data;
        end
    end

    assign o_rs1_data = (i_rs1_addr == 5'd0) ? 32'd0 : regs[i_rs1_addr];
    assign o_rs2_data = (i_rs2_addr == 5'd0) ? 32'd0 : regs[i_rs2_addr];
endmodule

// ----------------------------------------------------------------------------
// Data memory: combinational read, synchronous write, no reset of contents.
// ----------------------------------------------------------------------------
module rv_cpu_dmem #(
    parameter int DEPTH = 256
) (
    input  logic        clk,
    input  logic [29:0] i_word_addr,
    input  logic        i_we,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata
);
    localparam int c_ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0]         mem [0:DEPTH-1];
    logic [c_ADDR_W-1:0] w_index;

    assign w_index = c_ADDR_W'(i_word_addr % 30'(DEPTH));
    assign o_rdata = mem[w_index];

    // Store the word at the clock edge that ends the store's cycle
    always_ff @(posedge clk) begin
        if (i_we) begin
            mem[w_index] <= i_wdata;
        end
    end
endmodule

// ----------------------------------------------------------------------------
// Core top level
// ----------------------------------------------------------------------------
module rv_cpu_single_cycle #(
    parameter int          IMEM_DEPTH = 256,
    parameter int          DMEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic clk,
    input  logic rst
);
    localparam logic [6:0] c_OP_REG    = 7'b0110011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [2:0] c_F3_WORD   = 3'b010;

    logic [31:0] pc;
    logic [31:0] instr;
    logic [6:0]  opcode;

    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [2:0]  w_funct3;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_j;
    logic [31:0] w_imm_u;
    logic [31:0] w_rs1_data;
    logic [31:0] w_rs2_data;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_jalr_target;
    logic [31:0] w_ls_imm;
    logic [29:0] w_ls_word;
    logic [31:0] w_mem_rdata;
    logic [31:0] w_alu_b;
    logic        w_alu_alt;
    logic [31:0] w_alu_result;
    logic        w_branch_taken;
    logic [31:0] w_next_pc;
    logic        w_rf_we;
    logic [31:0] w_wb_data;
    logic        w_mem_we;

    rv_cpu_imem #(
        .DEPTH       (IMEM_DEPTH)
    ) u_imem (
        .i_word_addr (pc[31:2]),
        .o_instr     (instr)
    );

    assign opcode   = instr[6:0];
    assign w_rd     = instr[11:7];
    assign w_funct3 = instr[14:12];
    assign w_rs1    = instr[19:15];
    assign w_rs2    = instr[24:20];

    assign w_imm_i = {{20{instr[31]}}, instr[31:20]};
    assign w_imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign w_imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign w_imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign w_imm_u = {instr[31:12], 12'd0};

    rv_cpu_regfile u_regfile (
        .clk         (clk),
        .rst         (rst),
        .i_rs1_addr  (w_rs1),
        .i_rs2_addr  (w_rs2),
        .o_rs1_data  (w_rs1_data),
        .o_rs2_data  (w_rs2_data),
        .i_we        (w_rf_we),
        .i_rd_addr   (w_rd),
        .i_rd_data   (w_wb_data)
    );

    assign w_pc_plus4    = pc + 32'd4;
    // Target is formed from the pre-write rs1, so rd==rs1 is harmless
    assign w_jalr_target = (w_rs1_data + w_imm_i) & ~32'd1;

    // Loads use the I immediate, stores the S immediate; byte offset is dropped
    assign w_ls_imm  = (opcode == c_OP_STORE) ? w_imm_s : w_imm_i;
    assign w_ls_word = 30'((w_rs1_data + w_ls_imm) >> 2);

    rv_cpu_dmem #(
        .DEPTH       (DMEM_DEPTH)
    ) u_mem (
        .clk         (clk),
        .i_word_addr (w_ls_word),
        .i_we        (w_mem_we & ~rst),
        .i_wdata     (w_rs2_data),
        .o_rdata     (w_mem_rdata)
    );

    // ALU shared by register and immediate forms; bit 30 selects sub / sra
    always_comb begin
        w_alu_b      = (opcode == c_OP_REG) ? w_rs2_data : w_imm_i;
        w_alu_alt    = instr[30] & ((opcode == c_OP_REG) || (w_funct3 == 3'b101));
        w_alu_result = '0;
        case (w_funct3)
            3'b000:  w_alu_result = w_alu_alt ? (w_rs1_data - w_alu_b) : (w_rs1_data + w_alu_b);
            3'b001:  w_alu_result = w_rs1_data << w_alu_b[4:0];
            3'b010:  w_alu_result = {31'd0, $signed(w_rs1_data) < $signed(w_alu_b)};
            3'b011:  w_alu_result = {31'd0, w_rs1_data < w_alu_b};
            3'b100:  w_alu_result = w_rs1_data ^ w_alu_b;
            3'b101:  w_alu_result = w_alu_alt ? ($signed(w_rs1_data) >>> w_alu_b[4:0])
                                              : (w_rs1_data >> w_alu_b[4:0]);
            3'b110:  w_alu_result = w_rs1_data | w_alu_b;
            default: w_alu_result = w_rs1_data & w_alu_b;
        endcase
    end

    // Branch condition; unsupported funct3 values never branch
    always_comb begin
        w_branch_taken = 1'b0;
        case (w_funct3)
            3'b000:  w_branch_taken = (w_rs1_data == w_rs2_data);
`ifdef RV_EXT_BRANCH_EN
            3'b001:  w_branch_taken = (w_rs1_data != w_rs2_data);
            3'b100:  w_branch_taken = ($signed(w_rs1_data) <  $signed(w_rs2_data));
            3'b101:  w_branch_taken = ($signed(w_rs1_data) >= $signed(w_rs2_data));
            3'b110:  w_branch_taken = (w_rs1_data <  w_rs2_data);
            3'b111:  w_branch_taken = (w_rs1_data >= w_rs2_data);
`endif
            default: w_branch_taken = 1'b0;
        endcase
    end

    // Main decode: next pc, register writeback and store enable
    always_comb begin
        w_next_pc = w_pc_plus4;
        w_rf_we   = 1'b0;
        w_wb_data = w_alu_result;
        w_mem_we  = 1'b0;
        case (opcode)
            c_OP_REG, c_OP_IMM: begin
                w_rf_we = 1'b1;
            end
            c_OP_LOAD: begin
                if (w_funct3 == c_F3_WORD) begin
                    w_rf_we   = 1'b1;
                    w_wb_data = w_mem_rdata;
                end
            end
            c_OP_STORE: begin
                if (w_funct3 == c_F3_WORD) begin
                    w_mem_we = 1'b1;
                end
            end
            c_OP_BRANCH: begin
                if (w_branch_taken) begin
                    w_next_pc = pc + w_imm_b;
                end
            end
            c_OP_JAL: begin
                w_rf_we   = 1'b1;
                w_wb_data = w_pc_plus4;
                w_next_pc = pc + w_imm_j;
            end
            c_OP_JALR: begin
                w_rf_we   = 1'b1;
                w_wb_data = w_pc_plus4;
                w_next_pc = w_jalr_target;
            end
            c_OP_LUI: begin
                w_rf_we   = 1'b1;
                w_wb_data = w_imm_u;
            end
            default: begin
                w_next_pc = w_pc_plus4;
            end
        endcase
    end

    // Program counter: one instruction retires per clock
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= w_next_pc;
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_rv_cpu_single_cycle.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rv_cpu_single_cycle
//  Description : Self-checking bench for rv_cpu_single_cycle. An instruction
//                level reference model predicts the architectural effect of
//                every retired instruction into a scoreboard queue; a monitor
//                pops one entry per clock and compares against the core.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rv_cpu_single_cycle;
    localparam int IMEM_D = 256;
    localparam int DMEM_D = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    rv_cpu_single_cycle #(
        .IMEM_DEPTH (IMEM_D),
        .DMEM_DEPTH (DMEM_D),
        .RESET_PC   (32'h0)
    ) dut (
        .clk (clk),
        .rst (rst)
    );

    typedef struct {
        logic [31:0] pc;
        int          rd;
        logic [31:0] rdv;
        bit          st;
        int          maddr;
        logic [31:0] mval;
    } exp_t;

    exp_t        sb[$];
    exp_t        me;
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    logic [31:0] m_imem [IMEM_D];
    logic [31:0] m_mem  [DMEM_D];
    logic [31:0] m_regs [32];
    logic [31:0] m_pc;
    logic [31:0] prog[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- encoders ----------------
    function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
    endfunction
    function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, logic [6:0] op);
        logic [31:0] v = imm;
        return {v[11:0], 5'(rs1), 3'(f3), 5'(rd), op};
    endfunction
    function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3);
        logic [31:0] v = imm;
        return {v[11:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
        logic [31:0] v = imm;
        return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_j(int imm, int rd);
        logic [31:0] v = imm;
        return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'h6f};
    endfunction
    function automatic logic [31:0] addi(int rd, int rs1, int imm);
        return enc_i(imm, rs1, 0, rd, 7'h13);
    endfunction

    // ---------------- reference model ----------------
    function automatic logic [31:0] alu(int f3, logic [31:0] a, logic [31:0] b, bit alt);
        int sh = int'(b % 32);
        case (f3)
            0:       return alt ? a - b : a + b;
            1:       return a << sh;
            2:       return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3:       return (a < b) ? 32'd1 : 32'd0;
            4:       return a ^ b;
            5:       return alt ? 32'($signed(a) >>> sh) : a >> sh;
            6:       return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic exp_t model_step();
        exp_t        e;
        logic [31:0] ins, a, b, ii, is, ib, ij, res, nxt;
        int          rd, rs1, rs2, f3, idx;
        bit          wr, take;
        ins  = m_imem[(m_pc >> 2) % IMEM_D];
        rd   = int'(ins[11:7]);
        f3   = int'(ins[14:12]);
        rs1  = int'(ins[19:15]);
        rs2  = int'(ins[24:20]);
        a    = m_regs[rs1];
        b    = m_regs[rs2];
        ii   = 32'($signed(ins) >>> 20);
        is   = {ii[31:5], ins[11:7]};
        ib   = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
        ij   = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
        wr   = 0;
        take = 0;
        res  = 0;
        nxt  = m_pc + 4;
        e.st = 0;
        e.maddr = 0;
        e.mval  = 0;
        case (ins[6:0])
            7'h33: begin wr = 1; res = alu(f3, a, b, ins[30]); end
            7'h13: begin wr = 1; res = alu(f3, a, ii, (f3 == 5) && ins[30]); end
            7'h03: if (f3 == 2) begin wr = 1; res = m_mem[((a + ii) >> 2) % DMEM_D]; end
            7'h23: if (f3 == 2) begin
                idx = int'(((a + is) >> 2) % DMEM_D);
                e.st = 1; e.maddr = idx; e.mval = b; m_mem[idx] = b;
            end
            7'h63: begin
                case (f3)
                    0: take = (a == b);
`ifdef RV_EXT_BRANCH_EN
                    1: take = (a != b);
                    4: take = ($signed(a) < $signed(b));
                    5: take = ($signed(a) >= $signed(b));
                    6: take = (a < b);
                    7: take = (a >= b);
`endif
                    default: take = 0;
                endcase
                if (take) nxt = m_pc + ib;
            end
            7'h6f: begin wr = 1; res = m_pc + 4; nxt = m_pc + ij; end
            7'h67: begin wr = 1; res = m_pc + 4; nxt = (a + ii) & 32'hffff_fffe; end
            7'h37: begin wr = 1; res = {ins[31:12], 12'h0}; end
            default: ;
        endcase
        if (wr && rd != 0) m_regs[rd] = res;
        e.rd  = wr ? rd : 0;
        e.rdv = res;
        m_pc  = nxt;
        e.pc  = nxt;
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        int          rd, rs1, rs2, f3, imm, f7;
        logic [31:0] v;
        logic [6:0]  ops [4];
        rd  = $urandom_range(0, 7);
        rs1 = $urandom_range(0, 7);
        rs2 = $urandom_range(0, 7);
        f3  = $urandom_range(0, 7);
        imm = int'($urandom_range(0, 4095)) - 2048;
        v   = $urandom;
        ops[0] = 7'h0f; ops[1] = 7'h73; ops[2] = 7'h17; ops[3] = 7'h7f;
        case ($urandom_range(0, 11))
            0, 1: begin
                f7 = ((f3 == 0 || f3 == 5) && $urandom_range(0, 1) == 1) ? 32 : 0;
                return enc_r(f7, rs2, rs1, f3, rd);
            end
            2, 3: begin
                if (f3 == 1) imm = $urandom_range(0, 31);
                else if (f3 == 5) imm = int'($urandom_range(0, 31)) + ($urandom_range(0, 1) == 1 ? 1024 : 0);
                return enc_i(imm, rs1, f3, rd, 7'h13);
            end
            4:  return enc_i(imm, rs1, 2, rd, 7'h03);
            5:  return enc_s(imm, rs2, rs1, 2);
            6:  return ($urandom_range(0, 1) == 1) ? enc_i(imm, rs1, (f3 == 2) ? 0 : f3, rd, 7'h03)
                                                   : enc_s(imm, rs2, rs1, (f3 == 2) ? 1 : f3);
            7:  return enc_b((int'($urandom_range(0, 63)) - 32) * 4, rs2, rs1, f3);
            8:  return enc_j((int'($urandom_range(0, 63)) - 32) * 4, rd);
            9:  return enc_i(imm, rs1, f3, rd, 7'h67);
            10: return {v[31:12], 5'(rd), 7'h37};
            default: return {v[31:7], ops[$urandom_range(0, 3)]};
        endcase
    endfunction

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        if (mon_en) begin
            #1;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: got no expected entry, required one per retired instruction");
            end else begin
                me = sb.pop_front();
                check("pc", dut.pc, me.pc);
                if (me.rd != 0) check($sformatf("x%0d", me.rd), dut.u_regfile.regs[me.rd], me.rdv);
                check("x0", dut.u_regfile.regs[0], 32'h0);
                if (me.st) check($sformatf("mem[%0d]", me.maddr), dut.u_mem.mem[me.maddr], me.mval);
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic model_reset();
        m_pc = 32'h0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_pc"}, dut.pc, 32'h0);
        for (int i = 0; i < 32; i++) check($sformatf("%s_x%0d", tag, i), dut.u_regfile.regs[i], 32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        check_reset_state("rst");
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) sb.push_back(model_step());
        rst    = 1'b0;
        mon_en = 1'b1;
        repeat (n) @(negedge clk);
        mon_en = 1'b0;
        check("sb_empty", 32'(sb.size()), 32'h0);
    endtask

    task automatic load_prog();
        for (int i = 0; i < IMEM_D; i++) begin
            m_imem[i] = (i < prog.size()) ? prog[i] : 32'h0000_0013;
            dut.u_imem.imem[i] = m_imem[i];
        end
        for (int i = 0; i < DMEM_D; i++) begin
            m_mem[i] = 32'h0;
            dut.u_mem.mem[i] = 32'h0;
        end
    endtask

    task automatic final_regs(input string tag);
        for (int i = 0; i < 32; i++) check($sformatf("%s_x%0d", tag, i), dut.u_regfile.regs[i], m_regs[i]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        // R-type with back-to-back dependency
        prog = {};
        prog.push_back(addi(1, 0, 10));
        prog.push_back(addi(2, 0, 20));
        prog.push_back(addi(3, 0, 7));
        prog.push_back(enc_r(0, 2, 1, 0, 5));
        prog.push_back(enc_r(0, 3, 5, 0, 6));
        load_prog();
        do_reset();
        run_cycles(5);
        check("rtype_x5", dut.u_regfile.regs[5], 32'd30);
        check("rtype_x6", dut.u_regfile.regs[6], 32'd37);

        // Reset mid-program, then restart from imem[0]
        do_reset();
        run_cycles(3);
        rst = 1'b1;
        @(negedge clk);
        model_reset();
        check_reset_state("midrst");
        run_cycles(5);
        check("restart_x5", dut.u_regfile.regs[5], 32'd30);
        check("restart_x6", dut.u_regfile.regs[6], 32'd37);

        // I-type and x0 write discard
        prog = {};
        prog.push_back(addi(1, 0, 42));
        prog.push_back(addi(2, 1, 5));
        prog.push_back(addi(0, 0, 9));
        load_prog();
        do_reset();
        run_cycles(3);
        check("itype_x2", dut.u_regfile.regs[2], 32'd47);
        check("itype_x0", dut.u_regfile.regs[0], 32'd0);

        // Store then load
        prog = {};
        prog.push_back(addi(1, 0, 40));
        prog.push_back(addi(3, 0, 7));
        prog.push_back(enc_s(8, 3, 1, 2));
        prog.push_back(enc_i(8, 1, 2, 5, 7'h03));
        load_prog();
        do_reset();
        run_cycles(4);
        check("sw_mem12", dut.u_mem.mem[12], 32'd7);
        check("lw_x5", dut.u_regfile.regs[5], 32'd7);

        // Taken beq skips one instruction
        prog = {};
        prog.push_back(addi(2, 0, 42));
        prog.push_back(addi(3, 0, 42));
        prog.push_back(enc_b(8, 3, 2, 0));
        prog.push_back(addi(4, 0, 99));
        prog.push_back(addi(5, 0, 7));
        load_prog();
        do_reset();
        run_cycles(4);
        check("beq_x4", dut.u_regfile.regs[4], 32'd0);
        check("beq_x5", dut.u_regfile.regs[5], 32'd7);

        // jalr
        prog = {};
        prog.push_back(addi(1, 0, 12));
        prog.push_back(enc_i(0, 1, 0, 2, 7'h67));
        prog.push_back(addi(3, 0, 99));
        prog.push_back(addi(4, 0, 7));
        load_prog();
        do_reset();
        run_cycles(3);
        check("jalr_x2", dut.u_regfile.regs[2], 32'd8);
        check("jalr_x3", dut.u_regfile.regs[3], 32'd0);
        check("jalr_x4", dut.u_regfile.regs[4], 32'd7);

        // jal at pc=4
        prog = {};
        prog.push_back(32'h0000_0013);
        prog.push_back(enc_j(8, 2));
        prog.push_back(addi(3, 0, 99));
        prog.push_back(addi(4, 0, 7));
        load_prog();
        do_reset();
        run_cycles(3);
        check("jal_x2", dut.u_regfile.regs[2], 32'd8);
        check("jal_x3", dut.u_regfile.regs[3], 32'd0);
        check("jal_x4", dut.u_regfile.regs[4], 32'd7);

        // Randomized programs filling the whole instruction memory
        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < IMEM_D; i++) begin
                m_imem[i] = rand_instr();
                dut.u_imem.imem[i] = m_imem[i];
            end
            for (int i = 0; i < DMEM_D; i++) begin
                m_mem[i] = $urandom;
                dut.u_mem.mem[i] = m_mem[i];
            end
            do_reset();
            run_cycles(300);
            final_regs($sformatf("rand%0d", p));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/rv_cpu_single_cycle.md
Name:
rv_cpu_single_cycle

Overview:
- Single-cycle RV32I-subset processor core: fetch, decode, execute, memory access and writeback all complete in one clock.
- Top of the CPU hierarchy; it has no external bus. Instruction and data memories are internal arrays that the bench preloads and inspects through hierarchy.
- Fixed instance and signal names, which benches rely on:
  - instruction memory u_imem, array imem
  - register file u_regfile, array regs[0:31]
  - data memory u_mem, array mem
  - top-level signals pc, instr, opcode

Parameters:
- IMEM_DEPTH, 256, number of 32-bit instruction words.
- DMEM_DEPTH, 256, number of 32-bit data words.
- RESET_PC, 0, byte address loaded into pc on reset.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.

Behaviour:
- Reset: while rst is high at a rising edge:
  - pc <= RESET_PC.
  - All 32 registers <= 0.
  - No data-memory writes.
  - imem and mem contents are not touched, so a post-reset load from file stays intact.
- Fetch:
  - instr = imem[pc[31:2] mod IMEM_DEPTH], combinational.
  - opcode = instr[6:0].
  - pc[1:0] are ignored.
- Register file:
  - Two combinational read ports and one write port on the rising edge.
  - x0 always reads 0; writes to x0 are discarded.
  - Read-during-write in the same cycle returns the old value.
- Immediate formats: I, S, B, J, U, all sign-extended to 32 bits. B and J immediates have bit 0 = 0.
- Supported instructions:
  - R-type (0110011): add, sub, sll, slt, sltu, xor, srl, sra, or, and, decoded by funct3/funct7[5].
  - I-ALU (0010011): addi, slti, sltiu, xori, ori, andi, slli, srli, srai.
  - lw (0000011, funct3 010): rd <= mem[(rs1+imm)[31:2] mod DMEM_DEPTH], combinational read.
  - sw (0100011, funct3 010): mem[(rs1+imm)[31:2]] <= rs2 at the clock edge.
  - beq (1100011, funct3 000): if rs1==rs2 then pc <= pc+immB, else pc <= pc+4.
  - jal (1101111): rd <= pc+4; pc <= pc+immJ.
  - jalr (1100111): rd <= pc+4; pc <= (rs1+immI) & ~1. The target uses the pre-write rs1 value, even when rd==rs1.
  - lui (0110111): rd <= immU.
- Arithmetic:
  - 32-bit wrap-around with no overflow traps.
  - Shift amount is taken from bits [4:0].
- All other instructions advance pc by 4 with no register or memory write.
  - This covers unknown opcodes, loads/stores other than word width, and branch funct3 values other than beq (unless the optional feature is enabled).
- Misaligned data addresses: low 2 bits are ignored.
- Addresses beyond a memory depth wrap modulo that depth.
- Latency:
  - Every instruction retires in exactly 1 cycle.
  - The result is visible in regs/mem after the rising edge that ends the instruction's cycle.
- The first instruction executes in the cycle following rst deassertion.

Optional Feature:
- Macro: RV_EXT_BRANCH_EN.
- Defined: opcode 1100011 also supports the following, with the same target computation as beq:
  - bne (001)
  - blt (100) and bge (101), signed compares
  - bltu (110) and bgeu (111), unsigned compares
- Undefined: only beq branches; all other branch funct3 values behave as a 4-byte NOP.

Test Plan:
- R-type:
  - Stimulus: regs x1=10, x2=20, x3=7; program add x5,x1,x2 then add x6,x5,x3.
  - Response: after 2 cycles x5=30, x6=37 (back-to-back dependency works).
- I-type / x0:
  - Stimulus: x1=42; program addi x2,x1,5 then addi x0,x0,9.
  - Response: x2=47, x0 stays 0.
- Store/load:
  - Stimulus: x1=40, x3=7; program sw x3,8(x1) then lw x5,8(x1).
  - Response: mem[12]=7, x5=7.
- Branch:
  - Stimulus: addi x2,x0,42; addi x3,x0,42; beq x2,x3,+8; addi x4,x0,99; addi x5,x0,7.
  - Response: x4=0 (skipped), x5=7.
- Jumps:
  - Stimulus: addi x1,x0,12; jalr x2,0(x1); addi x3,x0,99; addi x4,x0,7.
  - Response: x2=8, x3=0, x4=7.
  - Also: jal x2,8 at pc=4 gives x2=8 and skips the next instruction.
- Reset:
  - Stimulus: assert rst mid-program for 1 cycle.
  - Response: pc=0 and all regs=0 on the next cycle; the program restarts from imem[0] after deassertion.
